// File: rtl/event_counter_pkg.sv
// rtl/event_counter_pkg.sv - shared types and parameter check for multi_event_counter
package event_counter_pkg;

  typedef enum logic {CNT_WRAP, CNT_SAT} cnt_mode_e;

  // Terminal count must be reachable in WIDTH bits so count+1 never overflows.
  function automatic bit max_count_ok(input int width, input int max_count);
    return (width >= 1) && (width <= 31) && (max_count >= 1) &&
           (max_count <= (1 << width) - 1);
  endfunction

endpackage

// File: rtl/pos_edge_det.sv
// rtl/pos_edge_det.sv - rising-edge detector, used when MULTI_EVENT_CNT_EDGE_DET_EN is defined
module pos_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic sig,
  output logic edge_det
);

  logic r_sig_q;

  always_ff @(posedge clk) begin
    if (rst) r_sig_q <= 1'b0;
    else     r_sig_q <= sig;
  end

  assign edge_det = sig & ~r_sig_q;

endmodule

// File: rtl/multi_event_counter.sv
// rtl/multi_event_counter.sv - N-channel event counter with wrap/saturate terminal count
// MULTI_EVENT_CNT_EDGE_DET_EN: count only rising edges of sig instead of every high cycle.
module multi_event_counter
  import event_counter_pkg::*;
#(
  parameter int N_CH      = 4,
  parameter int WIDTH     = 5,
  parameter int MAX_COUNT = 10
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic                       sat_mode,
  input  logic [N_CH-1:0]            sig,
  input  logic [N_CH-1:0]            clr,
  output logic [N_CH-1:0][WIDTH-1:0] count,
  output logic [N_CH-1:0]            max_reached,
  output logic [N_CH-1:0]            at_max,
  output logic                       any_max
);

  localparam logic [WIDTH-1:0] C_MAX = WIDTH'(MAX_COUNT);
  localparam logic [WIDTH-1:0] C_ONE = WIDTH'(1);

  if (!max_count_ok(WIDTH, MAX_COUNT)) begin : g_param_err
    $error("multi_event_counter: MAX_COUNT must be in 1..2**WIDTH-1");
  end

  cnt_mode_e       w_mode;
  logic [N_CH-1:0] w_ev;
  logic [N_CH-1:0] w_inc;
  logic [N_CH-1:0] w_max_nxt_vec;
  logic            r_any_max;

  assign w_mode = sat_mode ? CNT_SAT : CNT_WRAP;

`ifdef MULTI_EVENT_CNT_EDGE_DET_EN
  for (genvar i = 0; i < N_CH; i++) begin : g_edge
    pos_edge_det u_edge (
      .clk      (clk),
      .rst      (rst),
      .sig      (sig[i]),
      .edge_det (w_ev[i])
    );
  end
`else
  assign w_ev = sig;
`endif

  assign w_inc = {N_CH{en}} & w_ev;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] w_count_nxt;
    logic             r_max;
    logic             w_max_nxt;

    // Priority: clear, then event; a held channel never re-pulses.
    always_comb begin
      w_count_nxt = r_count;
      w_max_nxt   = 1'b0;
      if (clr[i]) begin
        w_count_nxt = '0;
      end else if (w_inc[i]) begin
        if (r_count == C_MAX) begin
          if (w_mode == CNT_WRAP) begin
            w_count_nxt = '0;
            w_max_nxt   = 1'b1;
          end
        end else begin
          w_count_nxt = r_count + C_ONE;
          w_max_nxt   = (w_mode == CNT_SAT) && (w_count_nxt == C_MAX);
        end
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        r_count <= '0;
        r_max   <= 1'b0;
      end else begin
        r_count <= w_count_nxt;
        r_max   <= w_max_nxt;
      end
    end

    assign count[i]         = r_count;
    assign max_reached[i]   = r_max;
    assign at_max[i]        = (r_count == C_MAX);
    assign w_max_nxt_vec[i] = w_max_nxt;
  end

  // Registered from the same next-state terms so it lines up with max_reached.
  always_ff @(posedge clk) begin
    if (rst) r_any_max <= 1'b0;
    else     r_any_max <= |w_max_nxt_vec;
  end

  assign any_max = r_any_max;

endmodule
